// File: rtl/fc_argmax_engine_pkg.sv
// Shared definitions for the FC/argmax engine: FSM encoding, the 7-segment
// digit table and a width helper used for address/index port sizing.
package fc_argmax_engine_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_BIAS = 3'd1,
        S_MAC  = 3'd2,
        S_ARG  = 3'd3,
        S_DONE = 3'd4
    } fsm_state_e;

    // Plain-vector copies of the state encoding for the engine's state register
    localparam logic [2:0] ST_IDLE = 3'(S_IDLE);
    localparam logic [2:0] ST_BIAS = 3'(S_BIAS);
    localparam logic [2:0] ST_MAC  = 3'(S_MAC);
    localparam logic [2:0] ST_ARG  = 3'(S_ARG);
    localparam logic [2:0] ST_DONE = 3'(S_DONE);

    // Active-low gfedcba patterns for hex digits 0..F
    localparam logic [6:0] SEG_LUT [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    // Ceiling log2, never below 1 so every port keeps at least one bit
    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/fc_argmax_engine_hex7seg_dec.sv
// Combinational hex digit to active-low 7-segment decoder.
module hex7seg_dec
    import fc_argmax_engine_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    assign seg_o = SEG_LUT[nibble_i];

endmodule

// File: rtl/fc_argmax_engine.sv
// Fully-connected layer with bias, optional ReLU and argmax. LANES output
// neurons share each x fetch; groups of lanes are processed one after another.
module fc_argmax_engine
    import fc_argmax_engine_pkg::*;
#(
    parameter int  N_IN   = 400,
    parameter int  N_OUT  = 10,
    parameter int  LANES  = 1,
    parameter int  DATA_W = 8,
    parameter int  ACC_W  = 24,
    parameter int  IDX_W  = clog2_min1(N_OUT),
    localparam int NG     = N_OUT / LANES,
    localparam int XA_W   = clog2_min1(N_IN),
    localparam int WA_W   = clog2_min1(N_IN * NG),
    localparam int BA_W   = clog2_min1(NG)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     relu_en,
    output logic [XA_W-1:0]          x_addr,
    input  logic signed [DATA_W-1:0] x_rdata,
    output logic [WA_W-1:0]          w_addr,
    input  logic [LANES*DATA_W-1:0]  w_rdata,
    output logic [BA_W-1:0]          b_addr,
    input  logic [LANES*ACC_W-1:0]   b_rdata,
    output logic                     busy,
    output logic                     done,
    output logic [IDX_W-1:0]         class_idx,
    output logic signed [ACC_W-1:0]  class_score,
    output logic [6:0]               hex_seg
);

    localparam int                      LA_W      = clog2_min1(LANES);
    localparam int                      PW        = 2 * DATA_W;
    localparam logic [XA_W-1:0]         K_LAST    = XA_W'(N_IN - 1);
    localparam logic [BA_W-1:0]         G_LAST    = BA_W'(NG - 1);
    localparam logic [LA_W-1:0]         L_LAST    = LA_W'(LANES - 1);
    localparam logic [WA_W-1:0]         W_STRIDE  = WA_W'(N_IN);
    localparam logic signed [ACC_W-1:0] SCORE_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic [2:0]              state_q, state_d;
    logic [BA_W-1:0]         g_q, g_d;
    logic [XA_W-1:0]         k_q, k_d, k_nxt;
    logic [LA_W-1:0]         lane_q, lane_d;
    logic [WA_W-1:0]         w_base_q, w_base_d;
    logic [IDX_W-1:0]        cur_idx_q, cur_idx_d;
    logic                    relu_q, relu_d;
    logic signed [ACC_W-1:0] best_score_q, best_score_d;
    logic [IDX_W-1:0]        best_idx_q, best_idx_d;
    logic [IDX_W-1:0]        class_idx_q, class_idx_d;
    logic signed [ACC_W-1:0] class_score_q, class_score_d;
    logic                    done_q, done_d;
    logic                    busy_q, busy_d;
    logic signed [ACC_W-1:0] acc_vec [LANES];
    logic signed [ACC_W-1:0] acc_sel, score_s;
    logic [3:0]              idx_nib;

    // Per-lane MAC: the bias seeds the accumulator together with tap 0
    for (genvar j = 0; j < LANES; j++) begin : g_lane
        logic signed [DATA_W-1:0] w_s;
        logic signed [PW-1:0]     prod;
        logic signed [ACC_W-1:0]  prod_ext, bias_s, acc_q;

        assign w_s      = w_rdata[j*DATA_W +: DATA_W];
        assign bias_s   = b_rdata[j*ACC_W +: ACC_W];
        assign prod     = x_rdata * w_s;
        assign prod_ext = {{(ACC_W-PW){prod[PW-1]}}, prod};
        assign acc_vec[j] = acc_q;

        // Accumulate one tap per MAC cycle; the sum wraps, with no saturation
        always_ff @(posedge clk) begin
            if (state_q == ST_MAC) begin
                acc_q <= (k_q == '0) ? bias_s + prod_ext : acc_q + prod_ext;
            end
        end
    end

    // Pick the lane under inspection in ARG and apply the optional ReLU
    always_comb begin
        acc_sel = acc_vec[0];
        for (int j = 1; j < LANES; j++) begin
            if (lane_q == LA_W'(j)) acc_sel = acc_vec[j];
        end
        score_s = (relu_q && acc_sel[ACC_W-1]) ? '0 : acc_sel;
    end

    // RAM addresses: next tap is issued while the current tap's data arrives
    always_comb begin
        k_nxt  = (k_q == K_LAST) ? k_q : k_q + XA_W'(1);
        x_addr = '0;
        w_addr = '0;
        b_addr = '0;
        if (state_q == ST_BIAS) begin
            b_addr = g_q;
            w_addr = w_base_q;
        end else if (state_q == ST_MAC) begin
            b_addr = g_q;
            x_addr = k_nxt;
            w_addr = w_base_q + WA_W'(k_nxt);
        end
    end

    // FSM sequencing and running argmax; ties keep the earlier index
    always_comb begin
        state_d       = state_q;
        g_d           = g_q;
        k_d           = k_q;
        lane_d        = lane_q;
        w_base_d      = w_base_q;
        cur_idx_d     = cur_idx_q;
        relu_d        = relu_q;
        best_score_d  = best_score_q;
        best_idx_d    = best_idx_q;
        class_idx_d   = class_idx_q;
        class_score_d = class_score_q;
        done_d        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    relu_d       = relu_en;
                    g_d          = '0;
                    w_base_d     = '0;
                    cur_idx_d    = '0;
                    best_score_d = SCORE_MIN;
                    best_idx_d   = '0;
                    state_d      = ST_BIAS;
                end
            end
            ST_BIAS: begin
                k_d     = '0;
                state_d = ST_MAC;
            end
            ST_MAC: begin
                k_d = k_nxt;
                if (k_q == K_LAST) begin
                    lane_d  = '0;
                    state_d = ST_ARG;
                end
            end
            ST_ARG: begin
                if (score_s > best_score_q) begin
                    best_score_d = score_s;
                    best_idx_d   = cur_idx_q;
                end
                cur_idx_d = cur_idx_q + IDX_W'(1);
                lane_d    = lane_q + LA_W'(1);
                if (lane_q == L_LAST) begin
                    if (g_q == G_LAST) begin
                        // Results land as DONE begins so they are valid with done
                        class_idx_d   = best_idx_d;
                        class_score_d = best_score_d;
                        done_d        = 1'b1;
                        state_d       = ST_DONE;
                    end else begin
                        g_d      = g_q + BA_W'(1);
                        w_base_d = w_base_q + W_STRIDE;
                        state_d  = ST_BIAS;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // Control and result registers; reset abandons any run in progress
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            g_q           <= '0;
            k_q           <= '0;
            lane_q        <= '0;
            w_base_q      <= '0;
            cur_idx_q     <= '0;
            relu_q        <= 1'b0;
            class_idx_q   <= '0;
            class_score_q <= '0;
            done_q        <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            g_q           <= g_d;
            k_q           <= k_d;
            lane_q        <= lane_d;
            w_base_q      <= w_base_d;
            cur_idx_q     <= cur_idx_d;
            relu_q        <= relu_d;
            class_idx_q   <= class_idx_d;
            class_score_q <= class_score_d;
            done_q        <= done_d;
            busy_q        <= busy_d;
        end
    end

    // Best-so-far datapath; re-seeded on every accepted start
    always_ff @(posedge clk) begin
        best_score_q <= best_score_d;
        best_idx_q   <= best_idx_d;
    end

    if (IDX_W >= 4) begin : g_nib_full
        assign idx_nib = class_idx_q[3:0];
    end else begin : g_nib_pad
        assign idx_nib = {{(4-IDX_W){1'b0}}, class_idx_q};
    end

    hex7seg_dec u_hex (
        .nibble_i (idx_nib),
        .seg_o    (hex_seg)
    );

    assign busy        = busy_q;
    assign done        = done_q;
    assign class_idx   = class_idx_q;
    assign class_score = class_score_q;

endmodule

// File: tb/tb_fc_argmax_engine.sv
// Bench for fc_argmax_engine: small 4x4 two-lane instance driven from a vector
// table plus random data, and two 400x10 instances (1 and 2 lanes) on shared
// random data, all checked against a plain-arithmetic argmax model.
module tb_fc_argmax_engine;

    localparam int LAT_M  = (4 / 2) * (1 + 4 + 2) + 1;
    localparam int LAT_S1 = (10 / 1) * (1 + 400 + 1) + 1;
    localparam int LAT_S2 = (10 / 2) * (1 + 400 + 2) + 1;

    localparam logic [6:0] SEG_REF [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, start_m, start_s, relu;

    // Logical data store shared by all RAM models
    int     rx [400];
    int     rw [10][400];
    longint rb [10];

    int n_vec = 0;
    int n_fail = 0;

    // Small instance: N_IN=4, N_OUT=4, LANES=2, ACC_W=20
    logic [1:0]         m_xa;
    logic signed [7:0]  m_xr;
    logic [2:0]         m_wa;
    logic [15:0]        m_wr;
    logic [0:0]         m_ba;
    logic [39:0]        m_br;
    logic               m_busy, m_done;
    logic [1:0]         m_idx;
    logic signed [19:0] m_score;
    logic [6:0]         m_seg;

    fc_argmax_engine #(.N_IN(4), .N_OUT(4), .LANES(2), .DATA_W(8), .ACC_W(20)) u_dut (
        .clk(clk), .reset(reset), .start(start_m), .relu_en(relu),
        .x_addr(m_xa), .x_rdata(m_xr), .w_addr(m_wa), .w_rdata(m_wr),
        .b_addr(m_ba), .b_rdata(m_br), .busy(m_busy), .done(m_done),
        .class_idx(m_idx), .class_score(m_score), .hex_seg(m_seg)
    );

    always @(posedge clk) begin
        m_xr <= 8'(rx[m_xa]);
        for (int j = 0; j < 2; j++) begin
            m_wr[j*8 +: 8]   <= 8'(rw[(int'(m_wa) / 4) * 2 + j][int'(m_wa) % 4]);
            m_br[j*20 +: 20] <= 20'(rb[int'(m_ba) * 2 + j]);
        end
    end

    // Sweep instance 1: N_IN=400, N_OUT=10, LANES=1, ACC_W=26
    logic [8:0]         s1_xa;
    logic signed [7:0]  s1_xr;
    logic [11:0]        s1_wa;
    logic [7:0]         s1_wr;
    logic [3:0]         s1_ba;
    logic [25:0]        s1_br;
    logic               s1_busy, s1_done;
    logic [3:0]         s1_idx;
    logic signed [25:0] s1_score;
    logic [6:0]         s1_seg;

    fc_argmax_engine #(.N_IN(400), .N_OUT(10), .LANES(1), .DATA_W(8), .ACC_W(26)) u_s1 (
        .clk(clk), .reset(reset), .start(start_s), .relu_en(relu),
        .x_addr(s1_xa), .x_rdata(s1_xr), .w_addr(s1_wa), .w_rdata(s1_wr),
        .b_addr(s1_ba), .b_rdata(s1_br), .busy(s1_busy), .done(s1_done),
        .class_idx(s1_idx), .class_score(s1_score), .hex_seg(s1_seg)
    );

    always @(posedge clk) begin
        s1_xr <= 8'(rx[s1_xa]);
        s1_wr <= 8'(rw[int'(s1_wa) / 400][int'(s1_wa) % 400]);
        s1_br <= 26'(rb[s1_ba]);
    end

    // Sweep instance 2: N_IN=400, N_OUT=10, LANES=2, ACC_W=26
    logic [8:0]         s2_xa;
    logic signed [7:0]  s2_xr;
    logic [10:0]        s2_wa;
    logic [15:0]        s2_wr;
    logic [2:0]         s2_ba;
    logic [51:0]        s2_br;
    logic               s2_busy, s2_done;
    logic [3:0]         s2_idx;
    logic signed [25:0] s2_score;
    logic [6:0]         s2_seg;

    fc_argmax_engine #(.N_IN(400), .N_OUT(10), .LANES(2), .DATA_W(8), .ACC_W(26)) u_s2 (
        .clk(clk), .reset(reset), .start(start_s), .relu_en(relu),
        .x_addr(s2_xa), .x_rdata(s2_xr), .w_addr(s2_wa), .w_rdata(s2_wr),
        .b_addr(s2_ba), .b_rdata(s2_br), .busy(s2_busy), .done(s2_done),
        .class_idx(s2_idx), .class_score(s2_score), .hex_seg(s2_seg)
    );

    always @(posedge clk) begin
        s2_xr <= 8'(rx[s2_xa]);
        for (int j = 0; j < 2; j++) begin
            s2_wr[j*8 +: 8]   <= 8'(rw[(int'(s2_wa) / 400) * 2 + j][int'(s2_wa) % 400]);
            s2_br[j*26 +: 26] <= 26'(rb[int'(s2_ba) * 2 + j]);
        end
    end

    typedef struct {
        int x  [4];
        int wo [4];
        int b  [4];
        bit relu;
        int eidx;
        int escore;
    } vec_t;

    vec_t tbl [9];

    task automatic chk(input string nm, input longint act, input longint ev);
        n_vec++;
        if (act != ev) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, ev);
        end
    endtask

    function automatic longint wrapw(input longint v, input int w);
        longint m;
        m = longint'(1) <<< w;
        v = v & (m - 1);
        if (v >= m / 2) v = v - m;
        return v;
    endfunction

    // Reference: full dot products, modular accumulator, ReLU, first maximum wins
    function automatic void ref_model(input int n_in, input int n_out, input int acc_w,
                                      input bit rl, output int idx, output longint score);
        longint best;
        best = -(longint'(1) <<< (acc_w - 1));
        idx = 0;
        for (int o = 0; o < n_out; o++) begin
            longint s;
            s = rb[o];
            for (int k = 0; k < n_in; k++) s += longint'(rx[k]) * longint'(rw[o][k]);
            s = wrapw(s, acc_w);
            if (rl && s < 0) s = 0;
            if (s > best) begin
                best = s;
                idx = o;
            end
        end
        score = best;
    endfunction

    task automatic load_vec(input vec_t v);
        for (int o = 0; o < 4; o++) begin
            rb[o] = v.b[o];
            for (int k = 0; k < 4; k++) rw[o][k] = v.wo[o];
        end
        for (int k = 0; k < 4; k++) rx[k] = v.x[k];
        relu = v.relu;
    endtask

    // One run on the small instance; poke > 0 re-pulses start mid-run
    task automatic run_main(input string nm, input int eidx, input longint esc, input int poke);
        int cnt;
        @(negedge clk);
        start_m = 1'b1;
        @(negedge clk);
        start_m = 1'b0;
        cnt = 1;
        while (!m_done && cnt < 200) begin
            @(negedge clk);
            cnt++;
            start_m = (cnt == poke);
        end
        start_m = 1'b0;
        chk({nm, ".latency"}, cnt, LAT_M);
        chk({nm, ".idx"}, longint'(m_idx), eidx);
        chk({nm, ".score"}, longint'(m_score), esc);
        chk({nm, ".seg"}, longint'(m_seg), longint'(SEG_REF[eidx & 15]));
        chk({nm, ".busy_in_done"}, longint'(m_busy), 1);
        @(negedge clk);
        chk({nm, ".done_pulse"}, longint'(m_done), 0);
        chk({nm, ".busy_after"}, longint'(m_busy), 0);
    endtask

    initial begin
        int     ridx;
        longint rsc;
        int     c, c1, c2;
        bit     seen;

        tbl[0] = '{x:'{1,2,3,4}, wo:'{1,2,3,4}, b:'{0,0,0,0}, relu:1'b0, eidx:3, escore:40};
        tbl[1] = '{x:'{1,1,1,1}, wo:'{-1,-1,-1,-1}, b:'{-10,-1,-5,-3}, relu:1'b0, eidx:1, escore:-5};
        tbl[2] = '{x:'{1,1,1,1}, wo:'{-1,-1,-1,-1}, b:'{-10,-1,-5,-3}, relu:1'b1, eidx:0, escore:0};
        tbl[3] = '{x:'{0,0,0,0}, wo:'{0,0,0,0}, b:'{5,9,9,2}, relu:1'b0, eidx:1, escore:9};
        tbl[4] = '{x:'{0,0,0,0}, wo:'{0,0,0,0}, b:'{7,7,7,7}, relu:1'b0, eidx:0, escore:7};
        tbl[5] = '{x:'{0,0,0,0}, wo:'{0,0,0,0}, b:'{-524288,-524288,-524288,-524288}, relu:1'b0, eidx:0, escore:-524288};
        tbl[6] = '{x:'{127,127,127,127}, wo:'{127,127,127,127}, b:'{524287,0,0,0}, relu:1'b0, eidx:1, escore:64516};
        tbl[7] = '{x:'{0,0,0,0}, wo:'{0,0,0,0}, b:'{-100,-50,-20,-30}, relu:1'b0, eidx:2, escore:-20};
        tbl[8] = '{x:'{1,1,1,1}, wo:'{-1,-1,-1,-1}, b:'{-10,-1,6,-3}, relu:1'b1, eidx:2, escore:2};

        for (int o = 0; o < 10; o++) begin
            rb[o] = 0;
            for (int k = 0; k < 400; k++) rw[o][k] = 0;
        end
        for (int k = 0; k < 400; k++) rx[k] = 0;

        // Reset held 5 cycles with a start pulse inside it
        reset = 1'b1; start_m = 1'b0; start_s = 1'b0; relu = 1'b0;
        repeat (2) @(negedge clk);
        start_m = 1'b1;
        repeat (2) @(negedge clk);
        start_m = 1'b0;
        @(negedge clk);
        chk("rst.busy", longint'(m_busy), 0);
        chk("rst.done", longint'(m_done), 0);
        chk("rst.idx", longint'(m_idx), 0);
        chk("rst.score", longint'(m_score), 0);
        chk("rst.seg", longint'(m_seg), longint'(7'b1000000));
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("rst.idle_busy", longint'(m_busy), 0);
        end

        // Table of hand-derived vectors
        for (int i = 0; i < 9; i++) begin
            load_vec(tbl[i]);
            run_main($sformatf("tbl%0d", i), tbl[i].eidx, tbl[i].escore, -1);
        end

        // Random data on the small instance
        for (int t = 0; t < 6; t++) begin
            for (int o = 0; o < 4; o++) begin
                rb[o] = longint'(int'($urandom_range(0, 524287)) - 262144);
                for (int k = 0; k < 4; k++) rw[o][k] = int'($urandom_range(0, 255)) - 128;
            end
            for (int k = 0; k < 4; k++) rx[k] = int'($urandom_range(0, 255)) - 128;
            relu = 1'($urandom_range(0, 1));
            ref_model(4, 4, 20, relu, ridx, rsc);
            run_main($sformatf("rnd%0d", t), ridx, rsc, -1);
        end

        // Start re-pulsed mid-run must not disturb result or latency
        load_vec(tbl[0]);
        run_main("poke", 3, 40, 5);

        // Reset six cycles into a run
        @(negedge clk);
        start_m = 1'b1;
        @(negedge clk);
        start_m = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst_mid.busy", longint'(m_busy), 0);
        chk("rst_mid.idx", longint'(m_idx), 0);
        chk("rst_mid.score", longint'(m_score), 0);
        chk("rst_mid.seg", longint'(m_seg), longint'(7'b1000000));
        seen = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (m_done) seen = 1'b1;
        end
        chk("rst_mid.no_done", longint'(seen), 0);
        run_main("rst_mid.rerun", 3, 40, -1);

        // Parameter sweep on shared random data, two ReLU settings
        for (int r = 0; r < 2; r++) begin
            for (int o = 0; o < 10; o++) begin
                rb[o] = longint'(int'($urandom_range(0, 2097151)) - 1048576);
                for (int k = 0; k < 400; k++) rw[o][k] = int'($urandom_range(0, 255)) - 128;
            end
            for (int k = 0; k < 400; k++) rx[k] = int'($urandom_range(0, 255)) - 128;
            relu = 1'(r);
            ref_model(400, 10, 26, relu, ridx, rsc);
            @(negedge clk);
            start_s = 1'b1;
            @(negedge clk);
            start_s = 1'b0;
            c = 1; c1 = 0; c2 = 0;
            while ((c1 == 0 || c2 == 0) && c < 6000) begin
                if (s1_done && c1 == 0) c1 = c;
                if (s2_done && c2 == 0) c2 = c;
                @(negedge clk);
                c++;
            end
            chk($sformatf("sweep%0d.l1.latency", r), c1, LAT_S1);
            chk($sformatf("sweep%0d.l2.latency", r), c2, LAT_S2);
            chk($sformatf("sweep%0d.l1.idx", r), longint'(s1_idx), ridx);
            chk($sformatf("sweep%0d.l1.score", r), longint'(s1_score), rsc);
            chk($sformatf("sweep%0d.l1.seg", r), longint'(s1_seg), longint'(SEG_REF[ridx & 15]));
            chk($sformatf("sweep%0d.l2.idx", r), longint'(s2_idx), ridx);
            chk($sformatf("sweep%0d.l2.score", r), longint'(s2_score), rsc);
            repeat (4) @(negedge clk);
            chk($sformatf("sweep%0d.l1.idle", r), longint'(s1_busy), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
